// File: rtl/bcd_display_pkg.sv
// Shared types and seven-segment constants for the BCD display scanner.
// Segment bit order is {g,f,e,d,c,b,a}, active-high.
package bcd_display_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Codes 10-15 are not valid BCD; they render as a dash so bad data is visible.
    localparam logic [6:0] SEG7_LUT [16] = '{
        7'b0111111,  // 0
        7'b0000110,  // 1
        7'b1011011,  // 2
        7'b1001111,  // 3
        7'b1100110,  // 4
        7'b1101101,  // 5
        7'b1111101,  // 6
        7'b0000111,  // 7
        7'b1111111,  // 8
        7'b1101111,  // 9
        SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH
    };

endpackage

// File: rtl/bcd_display_scan_if.sv
// Digit bus from the converter plus the display-side outputs of the scanner.
// The converter/bench side uses master, the scanner uses slave.
interface bcd_display_scan_if #(
    parameter int numberOfDigits = 6
);

    logic [numberOfDigits-1:0][3:0] BinaryDecimal;
    logic                           enaIn;
    logic [6:0]                     seg;
    logic [numberOfDigits-1:0]      an;
    logic                           frameDone;
    logic                           loaded;

    modport master (
        output BinaryDecimal,
        output enaIn,
        input  seg,
        input  an,
        input  frameDone,
        input  loaded
    );

    modport slave (
        input  BinaryDecimal,
        input  enaIn,
        output seg,
        output an,
        output frameDone,
        output loaded
    );

endinterface

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to seven-segment pattern lookup.
module bcd_to_seg7
    import bcd_display_pkg::*;
(
    input  bcd_digit_t i_digit,
    output logic [6:0] o_seg
);

    assign o_seg = SEG7_LUT[i_digit];

endmodule

// File: rtl/bcd_display_scan.sv
// Captures the converter's BCD vector and scans it onto a multiplexed 7-segment display.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero positions (digit 0 always lit).
module bcd_display_scan
    import bcd_display_pkg::*;
#(
    parameter int numberOfDigits = 6,
    parameter int refreshDivider = 50000
) (
    input  logic               clk,
    input  logic               rst,
    bcd_display_scan_if.slave  bus
);

    localparam int CNT_W = (refreshDivider > 1) ? $clog2(refreshDivider) : 1;
    localparam int IDX_W = (numberOfDigits > 1) ? $clog2(numberOfDigits) : 1;
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(refreshDivider - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(numberOfDigits - 1);

    logic [CNT_W-1:0]               r_slot;
    logic [IDX_W-1:0]               r_index;
    logic [numberOfDigits-1:0][3:0] r_shadow;
    logic                           r_loaded;
    logic [6:0]                     r_seg;
    logic [numberOfDigits-1:0]      r_an;
    logic                           r_frame;

    logic                           w_slot_end;
    logic                           w_wrap;
    bcd_digit_t                     w_digit;
    logic [numberOfDigits-1:0]      w_onehot;
    logic [numberOfDigits-1:0]      w_lit;
    logic                           w_lit_cur;
    logic [6:0]                     w_seg_raw;

    assign w_slot_end = (r_slot == SLOT_LAST);
    assign w_wrap     = w_slot_end && (r_index == IDX_LAST);

    // Slot counter and digit index; the index only moves at the end of a slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_slot  <= '0;
            r_index <= '0;
        end else if (w_slot_end) begin
            r_slot  <= '0;
            r_index <= (r_index == IDX_LAST) ? '0 : (r_index + IDX_W'(1));
        end else begin
            r_slot  <= r_slot + CNT_W'(1);
            r_index <= r_index;
        end
    end

    // Shadow capture: every edge with the strobe high takes a fresh copy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shadow <= '0;
            r_loaded <= 1'b0;
        end else if (bus.enaIn) begin
            r_shadow <= bus.BinaryDecimal;
            r_loaded <= 1'b1;
        end else begin
            r_shadow <= r_shadow;
            r_loaded <= r_loaded;
        end
    end

    // Select the current digit with an AND-OR mux so no index can fall outside the vector.
    always_comb begin
        w_digit  = 4'd0;
        w_onehot = '0;
        for (int p = 0; p < numberOfDigits; p++) begin
            w_onehot[p] = (r_index == IDX_W'(p));
            w_digit     = w_digit | (w_onehot[p] ? r_shadow[p] : 4'd0);
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // A position stays lit once any digit at or above it is non-zero; dashes count as non-zero.
    always_comb begin
        logic w_seen;
        w_seen = 1'b0;
        w_lit  = '0;
        for (int p = numberOfDigits - 1; p >= 0; p--) begin
            w_seen   = w_seen | (r_shadow[p] != 4'd0) | (p == 0);
            w_lit[p] = w_seen;
        end
    end
`else
    assign w_lit = '1;
`endif

    assign w_lit_cur = |(w_lit & w_onehot);

    bcd_to_seg7 u_bcd_to_seg7 (
        .i_digit (w_digit),
        .o_seg   (w_seg_raw)
    );

    // Registered display outputs, one cycle behind index and shadow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_an    <= '0;
            r_seg   <= SEG_BLANK;
            r_frame <= 1'b0;
        end else begin
            r_an    <= r_loaded ? (w_onehot & w_lit) : '0;
            r_seg   <= (r_loaded && w_lit_cur) ? w_seg_raw : SEG_BLANK;
            r_frame <= w_wrap;
        end
    end

    assign bus.seg       = r_seg;
    assign bus.an        = r_an;
    assign bus.frameDone = r_frame;
    assign bus.loaded    = r_loaded;

endmodule
